// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS pipeline control logic: opcodes, functs,
// PC select codes and the hazard controller state type.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_ERET  = 6'h18;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_EXC = 2'd2;
  localparam logic [1:0] PCSEL_EPC = 2'd3;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    HALT    = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational decode of the D and EX instructions: load-use hazard,
// mfhi/mflo dependency on the mul/div unit, and ERET in EX.
module hazard_detect
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] d_instr,
  input  logic        d_valid,
  input  logic [31:0] ex_instr,
  input  logic        ex_valid,
  output logic        lu,
  output logic        md_dep,
  output logic        is_eret
);

  logic [5:0] d_op, d_funct, ex_op, ex_funct;
  logic [4:0] d_rs, d_rt, ex_rt;
  logic       ex_is_load, d_reads_rt;
  logic       unused_bits;

  assign d_op     = d_instr[31:26];
  assign d_rs     = d_instr[25:21];
  assign d_rt     = d_instr[20:16];
  assign d_funct  = d_instr[5:0];
  assign ex_op    = ex_instr[31:26];
  assign ex_rt    = ex_instr[20:16];
  assign ex_funct = ex_instr[5:0];

  assign unused_bits = ^{d_instr[15:6], ex_instr[25:21], ex_instr[15:6]};

  assign ex_is_load = (ex_op == OP_LB) || (ex_op == OP_LH) || (ex_op == OP_LW) ||
                      (ex_op == OP_LBU) || (ex_op == OP_LHU);

  // Immediate-form ALU ops write rt, so only R-type, branches and stores read it.
  assign d_reads_rt = (d_op == OP_RTYPE) || (d_op == OP_BEQ) || (d_op == OP_BNE) ||
                      (d_op == OP_SB) || (d_op == OP_SH) || (d_op == OP_SW);

  assign lu = ex_valid && d_valid && ex_is_load && (ex_rt != 5'd0) &&
              ((ex_rt == d_rs) || (d_reads_rt && (ex_rt == d_rt)));

  assign md_dep = d_valid && (d_op == OP_RTYPE) &&
                  ((d_funct == FN_MFHI) || (d_funct == FN_MFLO));

  assign is_eret = ex_valid && (ex_op == OP_COP0) && (ex_funct == FN_ERET);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller: stall/flush/bubble and PC select from hazards, branches
// and exceptions; owns EPC/CAUSE/EXL, the double-fault halt and a stall counter.
module pipe_hazard_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter int          CNT_W      = 16
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  input  logic [31:0]      D_instruction,
  input  logic             D_valid,
  input  logic [31:0]      EX_instruction,
  input  logic             EX_valid,
  input  logic [31:0]      EX_pc,
  input  logic [2:0]       EX_exception_signal,
  input  logic             EX_branch_taken,
  input  logic             MD_busy,
  output logic             PC_stall,
  output logic             D_stall,
  output logic             D_flush,
  output logic             EX_bubble,
  output logic [1:0]       PC_sel,
  output logic [31:0]      EPC,
  output logic [2:0]       CAUSE,
  output logic             EXL,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  state_t state, state_nxt;
  logic   lu, md_dep, is_eret, exc;
  logic   take_exc, do_eret;

  hazard_detect u_hazard_detect (
    .d_instr  (D_instruction),
    .d_valid  (D_valid),
    .ex_instr (EX_instruction),
    .ex_valid (EX_valid),
    .lu       (lu),
    .md_dep   (md_dep),
    .is_eret  (is_eret)
  );

  assign exc    = EX_valid && (EX_exception_signal != 3'd0);
  assign halted = (state == HALT);

  always_comb begin
    state_nxt = state;
    PC_stall  = 1'b0;
    D_stall   = 1'b0;
    D_flush   = 1'b0;
    EX_bubble = 1'b0;
    PC_sel    = PCSEL_SEQ;
    take_exc  = 1'b0;
    do_eret   = 1'b0;
    if (SYS_reset) begin
      D_flush   = 1'b1;
      EX_bubble = 1'b1;
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (exc && EXL) begin
            D_flush   = 1'b1;
            EX_bubble = 1'b1;
            state_nxt = HALT;
          end else if (exc) begin
            PC_sel    = PCSEL_EXC;
            D_flush   = 1'b1;
            EX_bubble = 1'b1;
            take_exc  = 1'b1;
          end else if (is_eret) begin
            PC_sel    = PCSEL_EPC;
            D_flush   = 1'b1;
            EX_bubble = 1'b1;
            do_eret   = 1'b1;
          end else if (EX_branch_taken) begin
            PC_sel    = PCSEL_BR;
            D_flush   = 1'b1;
            EX_bubble = 1'b1;
          end else if (lu || (md_dep && MD_busy)) begin
            PC_stall  = 1'b1;
            D_stall   = 1'b1;
            EX_bubble = 1'b1;
            if (!lu) state_nxt = MD_WAIT;
          end
        end
        MD_WAIT: begin
          if (MD_busy) begin
            PC_stall  = 1'b1;
            D_stall   = 1'b1;
            EX_bubble = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
        HALT: begin
          PC_stall  = 1'b1;
          D_stall   = 1'b1;
          EX_bubble = 1'b1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // EXC_VECTOR is applied by the fetch mux when PC_sel selects it.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state       <= RUN;
      EPC         <= 32'd0;
      CAUSE       <= 3'd0;
      EXL         <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      if (take_exc) begin
        EPC   <= EX_pc;
        CAUSE <= EX_exception_signal;
        EXL   <= 1'b1;
      end else if (do_eret) begin
        EXL   <= 1'b0;
      end
      if (PC_stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core.
- Watches the decode stage (D_) and execute stage (EX_) instructions, the EX exception code and mul/div busy.
- Drives stall, flush and bubble controls plus PC redirect selection.
- Owns the exception state: EPC, CAUSE, EXL, the double-fault halt, and a stall performance counter.

Parameters:
EXC_VECTOR, 32'h0000_0080, PC loaded on exception entry
CNT_W, 16, width of the saturating stall counter

Ports:
SYS_clk  in  1  system clock
SYS_reset  in  1  synchronous, active-high reset
D_instruction  in  32  instruction in the IF/ID register
D_valid  in  1  D_instruction is live
EX_instruction  in  32  instruction in the ID/EX register
EX_valid  in  1  EX_instruction is live
EX_pc  in  32  PC of the EX instruction
EX_exception_signal  in  3  exception code from EX; 0 = none
EX_branch_taken  in  1  branch/jump resolved taken in EX
MD_busy  in  1  multiplier/divider still computing
PC_stall  out  1  hold PC
D_stall  out  1  hold IF/ID
D_flush  out  1  clear IF/ID to NOP
EX_bubble  out  1  load NOP into ID/EX next edge
PC_sel  out  2  0 seq, 1 branch target, 2 EXC_VECTOR, 3 EPC
EPC  out  32  saved exception PC
CAUSE  out  3  saved exception code
EXL  out  1  exception level active
halted  out  1  double fault, core frozen
stall_count  out  CNT_W  cycles spent stalled, saturating

Behaviour:
- All control outputs are combinational from the current state and inputs. Effect is at the next edge.
- EPC, CAUSE, EXL, state and stall_count are registered.
- Reset values: state RUN; EPC=0, CAUSE=0, EXL=0, stall_count=0, halted=0.
- While SYS_reset=1: D_flush=1, EX_bubble=1, PC_stall=0, PC_sel=0.
- Decode fields: op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0].
- Load in EX: op is one of 0x20, 0x21, 0x23, 0x24, 0x25.
- D reads rt when op=0 (R-type), or op is 0x04/0x05 (beq/bne), or op is 0x28/0x29/0x2B (stores).
- Load-use hazard (lu): EX_valid, D_valid, EX is a load, EX rt != 0, and (EX rt == D rs, or (D reads rt and EX rt == D rt)).
- mfhi/mflo in D: op=0 with funct 0x10 or 0x12.
- ERET in EX: op=0x10, funct=0x18.
- exc: EX_valid and EX_exception_signal != 0.
- States: RUN, MD_WAIT, HALT.
- Priority in RUN, highest first:
  1. exc with EXL=1: go to HALT. Outputs that cycle: D_flush=1, EX_bubble=1.
  2. exc with EXL=0: PC_sel=2, D_flush=1, EX_bubble=1. Next edge: EPC<=EX_pc, CAUSE<=code, EXL<=1.
  3. ERET: PC_sel=3, D_flush=1, EX_bubble=1. Next edge: EXL<=0.
  4. EX_branch_taken: PC_sel=1, D_flush=1, EX_bubble=1.
  5. lu: PC_stall=1, D_stall=1, EX_bubble=1. Exactly one cycle, since the load leaves EX.
  6. mfhi/mflo in D with MD_busy=1: same stall outputs as lu; go to MD_WAIT.
- MD_WAIT:
  - Hold PC_stall=1, D_stall=1, EX_bubble=1 while MD_busy=1.
  - When MD_busy=0: outputs deasserted that cycle; return to RUN.
  - exc and ERET cannot arrive here, since EX holds only bubbles.
- HALT:
  - PC_stall=1, D_stall=1, EX_bubble=1, halted=1.
  - Left only by SYS_reset.
  - EPC and CAUSE keep the first exception's values.
- stall_count: +1 on every cycle with PC_stall=1, including HALT. Saturates at all-ones; no wrap.
- D_stall and D_flush are never both 1. Flush wins, because redirect has higher priority.
- Reset asserted mid-MD_WAIT or mid-HALT returns to RUN at the next edge, with all registers at reset values.

Decomposition:
- Shared package mips_ctrl_pkg:
  - opcode/funct constants: OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_BEQ, OP_BNE, OP_SW, OP_SB, OP_SH, OP_COP0, FN_MFHI, FN_MFLO, FN_ERET.
  - PC_sel encoding PCSEL_SEQ, PCSEL_BR, PCSEL_EXC, PCSEL_EPC.
  - state enum RUN, MD_WAIT, HALT.
- One sub-module, hazard_detect: purely combinational decode of D/EX instructions producing lu, md_dep and is_eret.
- The FSM and exception registers stay in pipe_hazard_ctrl.

Test Plan:
- Reset, then EX=lw $8,0($9) (0x8D280000) and D=add $10,$8,$11 (0x010B5020) -> one cycle of PC_stall=D_stall=EX_bubble=1; stall_count=1; next cycle all 0.
- EX=lw $0,... with D using $0 -> no stall. EX=lw $8 with D=addi $12,$8,1 (0x210C0001) -> stall. D=addi $8,$12,1, where rt is a destination -> no stall.
- EX_branch_taken=1 while lu is also true -> PC_sel=1, D_flush=1, EX_bubble=1, PC_stall=0.
- EX_valid=1, EX_pc=0x0000_0040, EX_exception_signal=3'b010 -> PC_sel=2 and flushes; next cycle EPC=0x40, CAUSE=2, EXL=1. Then EX=ERET (0x42000018) -> PC_sel=3; next cycle EXL=0.
- Exception with EXL=1 -> halted=1 and PC_stall=1 indefinitely; EPC unchanged; pulse SYS_reset -> halted=0, EXL=0, stall_count=0.
- D=mfhi (0x00004010) with MD_busy=1 for 5 cycles -> 5 stall cycles in MD_WAIT, release on the cycle MD_busy=0; stall_count=5. Preload near all-ones and confirm it saturates.
